// File: rtl/e203_ifu_ift2icb_mo_pkg.sv
// rtl/e203_ifu_ift2icb_mo_pkg.sv - shared defaults and tracker entry sizing for the fetch-to-ICB bridge
package e203_ifu_ift2icb_mo_pkg;

  localparam int E203_IFU_PC_W    = 32;
  localparam int E203_IFU_NTGT    = 2;
  localparam int E203_IFU_OUTS_DP = 2;

  // Target index width; a single target still needs one bit to name it.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tracker entry is {tgt_idx, kill}.
  localparam int E203_IFU_TRK_W = idx_w(E203_IFU_NTGT) + 1;

endpackage

// File: rtl/e203_ifu_ift2icb_mo_if.sv
// rtl/e203_ifu_ift2icb_mo_if.sv - IFU request/response and per-target ICB bundle
interface e203_ifu_ift2icb_mo_if
  import e203_ifu_ift2icb_mo_pkg::*;
#(
  parameter int PC_W = E203_IFU_PC_W,
  parameter int NTGT = E203_IFU_NTGT
);
  logic                 ifu_req_valid;
  logic                 ifu_req_ready;
  logic [PC_W-1:0]      ifu_req_pc;
  logic                 ifu_req_flush;
  logic                 ifu_rsp_valid;
  logic                 ifu_rsp_ready;
  logic                 ifu_rsp_err;
  logic [31:0]          ifu_rsp_instr;
  logic [NTGT*PC_W-1:0] tgt_base;
  logic [NTGT*PC_W-1:0] tgt_mask;
  logic [NTGT-1:0]      tgt_cmd_valid;
  logic [NTGT-1:0]      tgt_cmd_ready;
  logic [PC_W-1:0]      tgt_cmd_addr;
  logic [NTGT-1:0]      tgt_rsp_valid;
  logic [NTGT-1:0]      tgt_rsp_ready;
  logic [NTGT-1:0]      tgt_rsp_err;
  logic [NTGT*32-1:0]   tgt_rsp_rdata;

  // Bridge side.
  modport master (
    input  ifu_req_valid, ifu_req_pc, ifu_req_flush, ifu_rsp_ready,
    input  tgt_base, tgt_mask, tgt_cmd_ready, tgt_rsp_valid, tgt_rsp_err, tgt_rsp_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
    output tgt_cmd_valid, tgt_cmd_addr, tgt_rsp_ready
  );

  // IFU controller plus targets.
  modport slave (
    output ifu_req_valid, ifu_req_pc, ifu_req_flush, ifu_rsp_ready,
    output tgt_base, tgt_mask, tgt_cmd_ready, tgt_rsp_valid, tgt_rsp_err, tgt_rsp_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
    input  tgt_cmd_valid, tgt_cmd_addr, tgt_rsp_ready
  );

endinterface

// File: rtl/e203_ifu_ift2icb_mo_bypbuf.sv
// rtl/e203_ifu_ift2icb_mo_bypbuf.sv - bypass buffer, zero latency when empty, flushable
module e203_ifu_ift2icb_mo_bypbuf #(
  parameter int DW = 33,
  parameter int DP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data
);
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int SD = 2 ** PW;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem [SD];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] cnt;
  logic          empty, full, wr, rd;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DP));
  assign i_ready = ~full;
  assign o_valid = ~flush & (~empty | i_valid);
  assign o_data  = empty ? i_data : mem[rptr];
  // Store only what the consumer did not take straight through.
  assign wr      = i_valid & ~full & ~(empty & o_ready) & ~flush;
  assign rd      = ~empty & o_ready & ~flush;

  // Entry storage; data needs no reset since cnt qualifies it.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= i_data;
  end

  // Pointer/count update; flush drops every held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= inc(wptr);
      if (rd) rptr <= inc(rptr);
      if (wr && !rd)      cnt <= cnt + 1'b1;
      else if (rd && !wr) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/e203_ifu_ift2icb_mo_trk.sv
// rtl/e203_ifu_ift2icb_mo_trk.sv - in-order tracker of outstanding fetches with kill-all
module e203_ifu_ift2icb_mo_trk
  import e203_ifu_ift2icb_mo_pkg::*;
#(
  parameter int DP    = E203_IFU_OUTS_DP,
  parameter int IDX_W = E203_IFU_TRK_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  input  logic             kill_all,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_kill,
  output logic [IDX_W-1:0] tail_idx
);
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int SD = 2 ** PW;
  localparam int CW = $clog2(DP + 1);

  logic [IDX_W-1:0] idx_q [SD];
  logic [SD-1:0]    kill_q;
  logic [PW-1:0]    rptr, wptr, tptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DP));
  assign tptr      = (wptr == '0) ? PW'(DP - 1) : wptr - 1'b1;
  assign head_idx  = idx_q[rptr];
  assign head_kill = kill_q[rptr];
  assign tail_idx  = idx_q[tptr];

  // Pointer/count update; a push in the kill cycle lands live because its write is last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr   <= '0;
      wptr   <= '0;
      cnt    <= '0;
      kill_q <= '0;
      for (int i = 0; i < SD; i++) idx_q[i] <= '0;
    end else begin
      if (kill_all) kill_q <= '1;
      if (push) begin
        idx_q[wptr]  <= push_idx;
        kill_q[wptr] <= 1'b0;
        wptr         <= inc(wptr);
      end
      if (pop) rptr <= inc(rptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/e203_ifu_ift2icb_mo.sv
// rtl/e203_ifu_ift2icb_mo.sv - multi-outstanding IFU fetch to address-decoded ICB targets
module e203_ifu_ift2icb_mo
  import e203_ifu_ift2icb_mo_pkg::*;
#(
  parameter int PC_W    = E203_IFU_PC_W,
  parameter int NTGT    = E203_IFU_NTGT,
  parameter int OUTS_DP = E203_IFU_OUTS_DP,
  parameter int RSP_DP  = 1
) (
  input logic                  clk,
  input logic                  rst,
  e203_ifu_ift2icb_mo_if.master bus
);
  localparam int IDX_W = idx_w(NTGT);

  logic [IDX_W-1:0] sel, head_idx, tail_idx;
  logic             trk_full, trk_empty, head_kill, head_kill_eff;
  logic             ok, push, pop, head_vld, head_rdy;
  logic             buf_i_valid, buf_i_ready;
  logic [32:0]      buf_i_data, buf_o_data;
  logic             unused_default_region;

  // The last target's region is never decoded; it is the catch-all.
  assign unused_default_region = ^{bus.tgt_base[NTGT*PC_W-1 -: PC_W],
                                   bus.tgt_mask[NTGT*PC_W-1 -: PC_W]};

  // Region decode: lowest matching target wins, else the default target.
  always_comb begin
    sel = IDX_W'(NTGT - 1);
    for (int i = NTGT - 2; i >= 0; i--) begin
      if ((bus.ifu_req_pc & bus.tgt_mask[i*PC_W +: PC_W]) ==
          (bus.tgt_base[i*PC_W +: PC_W] & bus.tgt_mask[i*PC_W +: PC_W]))
        sel = IDX_W'(i);
    end
  end

  // Never switch target while anything is in flight, so returns stay ordered.
  assign ok   = ~trk_full & (trk_empty | (sel == tail_idx));
  assign push = bus.ifu_req_valid & bus.ifu_req_ready;

  assign bus.ifu_req_ready = ok & bus.tgt_cmd_ready[sel];
  assign bus.tgt_cmd_addr  = bus.ifu_req_pc;

  // One-hot command valid toward the selected target.
  always_comb begin
    bus.tgt_cmd_valid      = '0;
    bus.tgt_cmd_valid[sel] = bus.ifu_req_valid & ok;
  end

  // A flush also kills the head that pops in the same cycle.
  assign head_kill_eff = head_kill | bus.ifu_req_flush;
  assign head_vld      = ~trk_empty & bus.tgt_rsp_valid[head_idx];
  assign head_rdy      = ~trk_empty & (head_kill_eff | buf_i_ready);
  assign pop           = head_vld & head_rdy;
  assign buf_i_valid   = head_vld & ~head_kill_eff;
  assign buf_i_data    = {bus.tgt_rsp_err[head_idx], bus.tgt_rsp_rdata[int'(head_idx)*32 +: 32]};

  // Only the head target may hand back a response.
  always_comb begin
    bus.tgt_rsp_ready           = '0;
    bus.tgt_rsp_ready[head_idx] = head_rdy;
  end

  e203_ifu_ift2icb_mo_trk #(
    .DP    (OUTS_DP),
    .IDX_W (IDX_W)
  ) u_trk (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_idx  (sel),
    .pop       (pop),
    .kill_all  (bus.ifu_req_flush),
    .full      (trk_full),
    .empty     (trk_empty),
    .head_idx  (head_idx),
    .head_kill (head_kill),
    .tail_idx  (tail_idx)
  );

  e203_ifu_ift2icb_mo_bypbuf #(
    .DW (33),
    .DP (RSP_DP)
  ) u_rsp_buf (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.ifu_req_flush),
    .i_valid (buf_i_valid),
    .i_ready (buf_i_ready),
    .i_data  (buf_i_data),
    .o_valid (bus.ifu_rsp_valid),
    .o_ready (bus.ifu_rsp_ready),
    .o_data  (buf_o_data)
  );

  assign bus.ifu_rsp_err   = buf_o_data[32];
  assign bus.ifu_rsp_instr = buf_o_data[31:0];

endmodule
